// File: rtl/enq_pkt_desc_arb_if.sv
// enq_pkt_desc_arb_if: per-port FIFO pop side plus downstream valid/ready descriptor channel
`ifndef ENQ_PKT_DESC_NBITS
`define ENQ_PKT_DESC_NBITS 64
`endif
interface enq_pkt_desc_arb_if #(
  parameter int NUM_PORTS  = 4,
  parameter int PORT_NBITS = 2,
  parameter int WIDTH      = `ENQ_PKT_DESC_NBITS
);
  logic [NUM_PORTS-1:0]       fifo_empty;
  logic [NUM_PORTS*WIDTH-1:0] fifo_dout;
  logic [NUM_PORTS-1:0]       fifo_rd;
  logic                       out_valid;
  logic [WIDTH-1:0]           out_desc;
  logic [PORT_NBITS-1:0]      out_src;
  logic                       out_ready;
  modport master (input fifo_empty, fifo_dout, out_ready, output fifo_rd, out_valid, out_desc, out_src);
  modport slave (output fifo_empty, fifo_dout, out_ready, input fifo_rd, out_valid, out_desc, out_src);
endinterface

// File: rtl/enq_pkt_desc_arb.sv
// enq_pkt_desc_arb: round-robin burst scheduler draining per-port descriptor FIFOs into one valid/ready channel
`ifndef ENQ_PKT_DESC_NBITS
`define ENQ_PKT_DESC_NBITS 64
`endif
module enq_pkt_desc_arb #(
  parameter int NUM_PORTS  = 4,
  parameter int PORT_NBITS = 2,
  parameter int WIDTH      = `ENQ_PKT_DESC_NBITS,
  parameter int MAX_BURST  = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                enable,
  enq_pkt_desc_arb_if.master  bus,
  output logic                busy,
  output logic [31:0]         desc_cnt
);
  typedef enum logic [1:0] {IDLE, SETTLE, POP, HOLD} state_t;
  state_t                state_q, state_d;
  logic [PORT_NBITS-1:0] grant_q, grant_d, rr_ptr_q, rr_ptr_d, out_src_q, out_src_d;
  logic [3:0]            burst_cnt_q, burst_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [WIDTH-1:0]      out_desc_q, out_desc_d;
  logic [31:0]           desc_cnt_q, desc_cnt_d;
  // first requester at or after ptr, searching cyclically upward
  function automatic logic [PORT_NBITS-1:0] rr_pick(input logic [NUM_PORTS-1:0] req, input logic [PORT_NBITS-1:0] ptr);
    logic [PORT_NBITS-1:0] j;
    rr_pick = ptr;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      j = PORT_NBITS'((int'(ptr) + i) % NUM_PORTS);
      if (req[j]) rr_pick = j;
    end
  endfunction
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    out_valid_d = out_valid_q;
    out_desc_d  = out_desc_q;
    out_src_d   = out_src_q;
    desc_cnt_d  = desc_cnt_q;
    case (state_q)
      IDLE: if (enable && |(~bus.fifo_empty)) begin
        grant_d = rr_pick(~bus.fifo_empty, rr_ptr_q);
        state_d = SETTLE;
      end
      SETTLE: state_d = POP;
      POP: begin
        out_desc_d  = bus.fifo_dout[grant_q*WIDTH +: WIDTH];
        out_src_d   = grant_q;
        out_valid_d = 1'b1;
        burst_cnt_d = burst_cnt_q + 4'd1;
        state_d     = HOLD;
      end
      HOLD: if (bus.out_ready) begin
        out_valid_d = 1'b0;
        desc_cnt_d  = desc_cnt_q + 32'd1;
        if (enable && burst_cnt_q < 4'(MAX_BURST) && !bus.fifo_empty[grant_q]) state_d = POP;
        else begin
          rr_ptr_d    = (grant_q == PORT_NBITS'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
          burst_cnt_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_desc_q  <= '0;
      out_src_q   <= '0;
      desc_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      out_valid_q <= out_valid_d;
      out_desc_q  <= out_desc_d;
      out_src_q   <= out_src_d;
      desc_cnt_q  <= desc_cnt_d;
    end
  end
  assign bus.fifo_rd   = (state_q == POP) ? NUM_PORTS'(1) << grant_q : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_desc  = out_desc_q;
  assign bus.out_src   = out_src_q;
  assign busy          = state_q != IDLE;
  assign desc_cnt      = desc_cnt_q;
endmodule

// File: tb/tb_enq_pkt_desc_arb.sv
// tb_enq_pkt_desc_arb: randomized scoreboard bench with FIFO models and an abstract round-robin order model
module tb_enq_pkt_desc_arb;
  localparam int NP = 4;
  localparam int NB = 2;
  localparam int W  = 64;
  localparam int MB = 4;
  logic clk = 0;
  logic rstn, enable, busy;
  logic [31:0] desc_cnt;
  int n_cmp = 0, n_err = 0, acc = 0, pushed = 0, seqn = 0;
  logic [W-1:0] q[NP][$];
  logic [W-1:0] sb[NP][$];
  int order[$];
  enq_pkt_desc_arb_if #(.NUM_PORTS(NP), .PORT_NBITS(NB), .WIDTH(W)) bus ();
  enq_pkt_desc_arb #(.NUM_PORTS(NP), .PORT_NBITS(NB), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .bus(bus), .busy(busy), .desc_cnt(desc_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      bus.fifo_empty[p] = q[p].size() == 0;
      bus.fifo_dout[p*W +: W] = q[p].size() > 0 ? q[p][0] : '0;
    end
  endtask
  task automatic push(input int p, input logic [W-1:0] d);
    q[p].push_back(d);
    sb[p].push_back(d);
    pushed++;
    drive();
  endtask
  function automatic logic [W-1:0] mk(input int p);
    seqn++;
    return {8'(p), 24'(seqn), 32'($urandom)};
  endfunction
  // expected source sequence from the queued counts: bursts of up to MB, pointer moves past each served port
  task automatic build_order(input int start);
    int c[NP];
    int ptr, p;
    for (int i = 0; i < NP; i++) c[i] = q[i].size();
    ptr = start;
    order.delete();
    forever begin
      p = -1;
      for (int i = 0; i < NP; i++) if (p < 0 && c[(ptr + i) % NP] > 0) p = (ptr + i) % NP;
      if (p < 0) break;
      for (int k = 0; k < MB && c[p] > 0; k++) begin
        order.push_back(p);
        c[p]--;
      end
      ptr = (p + 1) % NP;
    end
  endtask
  task automatic cycle();
    logic [NP-1:0] rd;
    logic hs, hold, rst_edge;
    logic [W-1:0] d, tmp;
    logic [NB-1:0] s;
    rd = bus.fifo_rd;
    hs = ((bus.out_valid && bus.out_ready) === 1'b1) && rstn;
    hold = ((bus.out_valid && !bus.out_ready) === 1'b1) && rstn;
    d = bus.out_desc;
    s = bus.out_src;
    rst_edge = !rstn;
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) if (rd[p] === 1'b1 && q[p].size() > 0) tmp = q[p].pop_front();
    if (hs) begin
      if (sb[s].size() == 0) chk("acc_unexpected", 64'(sb[s].size()), 64'd1);
      else chk("acc_desc", d, sb[s].pop_front());
      if (order.size() > 0) chk("order_src", 64'(s), 64'(order.pop_front()));
      acc++;
    end
    if (rst_edge) begin
      acc = 0;
      for (int p = 0; p < NP; p++) sb[p] = q[p];
    end
    drive();
    @(negedge clk);
    if (hold) begin
      chk("hold_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_desc", bus.out_desc, d);
      chk("hold_src", 64'(bus.out_src), 64'(s));
    end
    if (bus.out_valid === 1'b1) chk("rd_in_hold", 64'(bus.fifo_rd), 64'd0);
    if (bus.fifo_rd !== '0) begin
      chk("rd_onehot", 64'($onehot(bus.fifo_rd)), 64'd1);
      chk("rd_nonempty", 64'(bus.fifo_rd & bus.fifo_empty), 64'd0);
    end
  endtask
  function automatic int left();
    int n = 0;
    for (int p = 0; p < NP; p++) n += q[p].size() + sb[p].size();
    return n;
  endfunction
  task automatic drain(input int budget, input bit rnd);
    int n = 0;
    while ((busy || left() > 0) && n < budget) begin
      if (rnd) bus.out_ready = $urandom_range(0, 2) != 0;
      cycle();
      n++;
    end
    bus.out_ready = 1;
    chk("drain_done", 64'(busy || left() > 0), 64'd0);
    chk("order_left", 64'(order.size()), 64'd0);
  endtask
  task automatic wait_valid(input int budget);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < budget) begin
      cycle();
      n++;
    end
    chk("valid_timeout", 64'(bus.out_valid), 64'd1);
  endtask
  task automatic do_reset();
    rstn = 0;
    cycle();
    rstn = 1;
    pushed = 0;
  endtask
  initial begin
    int n;
    rstn = 0;
    enable = 1;
    bus.out_ready = 1;
    drive();
    for (int p = 0; p < NP; p++) push(p, mk(p));
    repeat (3) begin
      cycle();
      chk("rst_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_rd", 64'(bus.fifo_rd), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_cnt", 64'(desc_cnt), 64'd0);
      chk("rst_desc", bus.out_desc, 64'd0);
      chk("rst_src", 64'(bus.out_src), 64'd0);
    end
    rstn = 1;
    build_order(0);
    chk("lat_idle", 64'(busy), 64'd0);
    cycle();
    chk("lat_settle_busy", 64'(busy), 64'd1);
    chk("lat_settle_rd", 64'(bus.fifo_rd), 64'd0);
    cycle();
    chk("lat_pop_rd", 64'(bus.fifo_rd), 64'b0001);
    cycle();
    chk("lat_valid", 64'(bus.out_valid), 64'd1);
    chk("lat_src", 64'(bus.out_src), 64'd0);
    drain(100, 0);
    chk("lat_cnt", 64'(desc_cnt), 64'd4);
    // single port 2
    do_reset();
    push(2, 64'hA5);
    build_order(0);
    cycle();
    chk("sp_settle_rd", 64'(bus.fifo_rd), 64'd0);
    cycle();
    chk("sp_rd", 64'(bus.fifo_rd), 64'b0100);
    cycle();
    chk("sp_valid", 64'(bus.out_valid), 64'd1);
    chk("sp_desc", bus.out_desc, 64'hA5);
    chk("sp_src", 64'(bus.out_src), 64'd2);
    cycle();
    chk("sp_idle_valid", 64'(bus.out_valid), 64'd0);
    chk("sp_idle_busy", 64'(busy), 64'd0);
    chk("sp_cnt", 64'(desc_cnt), 64'd1);
    // fairness
    do_reset();
    for (int p = 0; p < NP; p++) repeat (6) push(p, mk(p));
    build_order(0);
    drain(300, 0);
    chk("fair_cnt", 64'(desc_cnt), 64'd24);
    // random depths with random backpressure
    repeat (3) begin
      do_reset();
      for (int p = 0; p < NP; p++) repeat ($urandom_range(0, 9)) push(p, mk(p));
      build_order(0);
      drain(2000, 1);
      chk("rnd_cnt", 64'(desc_cnt), 64'(pushed));
    end
    // backpressure hold for 10 cycles
    do_reset();
    push(1, mk(1));
    bus.out_ready = 0;
    wait_valid(10);
    repeat (10) cycle();
    chk("bp_busy", 64'(busy), 64'd1);
    chk("bp_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_cnt0", 64'(desc_cnt), 64'd0);
    bus.out_ready = 1;
    cycle();
    chk("bp_cnt1", 64'(desc_cnt), 64'd1);
    chk("bp_valid_low", 64'(bus.out_valid), 64'd0);
    // enable drop in the second HOLD of a port-1 burst
    do_reset();
    repeat (4) push(1, mk(1));
    n = 0;
    while (!(acc == 1 && bus.out_valid === 1'b1) && n < 50) begin
      cycle();
      n++;
    end
    chk("en_reach_hold2", 64'(acc == 1 && bus.out_valid === 1'b1), 64'd1);
    bus.out_ready = 0;
    enable = 0;
    cycle();
    bus.out_ready = 1;
    cycle();
    chk("en_cnt", 64'(desc_cnt), 64'd2);
    repeat (10) begin
      cycle();
      chk("en_no_rd", 64'(bus.fifo_rd), 64'd0);
      chk("en_idle", 64'(busy), 64'd0);
    end
    push(0, mk(0));
    push(2, mk(2));
    build_order(2);
    enable = 1;
    drain(200, 0);
    // reset while holding a descriptor
    do_reset();
    repeat (3) push(3, mk(3));
    bus.out_ready = 0;
    wait_valid(20);
    rstn = 0;
    cycle();
    chk("mr_valid", 64'(bus.out_valid), 64'd0);
    chk("mr_cnt", 64'(desc_cnt), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    rstn = 1;
    push(0, mk(0));
    build_order(0);
    bus.out_ready = 1;
    drain(200, 0);
    chk("mr_cnt_end", 64'(desc_cnt), 64'd3);
    // wrap-around regrant of the only busy port
    do_reset();
    repeat (6) push(3, mk(3));
    build_order(0);
    drain(200, 0);
    chk("wrap_cnt", 64'(desc_cnt), 64'd6);
    // random streaming with live writes and enable toggling
    do_reset();
    order.delete();
    repeat (400) begin
      if ($urandom_range(0, 2) == 0) begin
        n = $urandom_range(0, NP - 1);
        push(n, mk(n));
      end
      bus.out_ready = $urandom_range(0, 3) != 0;
      enable = $urandom_range(0, 7) != 0;
      cycle();
    end
    enable = 1;
    drain(3000, 1);
    chk("stream_cnt", 64'(desc_cnt), 64'(pushed));
    chk("stream_acc", 64'(acc), 64'(pushed));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/enq_pkt_desc_arb.md
# enq_pkt_desc_arb

Round-robin scheduler that drains up to NUM_PORTS per-ingress enqueue packet-descriptor FIFOs (block-RAM synchronous FIFOs with registered read data) into a single downstream descriptor channel. It sits between the per-port descriptor FIFOs and the enqueue/queue-manager stage. It generates every FIFO pop, so the FIFOs never see a read from any other source. A per-port burst quantum (MAX_BURST) amortises arbitration overhead, and a valid/ready output applies downstream backpressure without losing descriptors.

## Interface
- NUM_PORTS, 4: number of requesting FIFOs, 2..16.
- PORT_NBITS, 2: log2(NUM_PORTS), width of the port index.
- WIDTH, `ENQ_PKT_DESC_NBITS: packed descriptor width.
- MAX_BURST, 4: maximum consecutive descriptors granted to one port, 1..15.

- clk  in  1  single clock; all logic on posedge.
- rstn  in  1  synchronous, active-low reset (codebase RESET_SIG).
- enable  in  1  when 0, no new grant starts; an in-flight descriptor still completes.
- fifo_empty  in  NUM_PORTS  per-port FIFO empty.
- fifo_dout  in  NUM_PORTS*WIDTH  per-port FIFO head; port i at [i*WIDTH +: WIDTH].
- fifo_rd  out  NUM_PORTS  one-cycle pop strobe, at most one bit high.
- out_valid  out  1  descriptor available.
- out_desc  out  WIDTH  packed descriptor.
- out_src  out  PORT_NBITS  index of the FIFO it came from.
- out_ready  in  1  downstream accept.
- busy  out  1  FSM not in IDLE.
- desc_cnt  out  32  total descriptors accepted downstream; wraps.

## Operation
- Registered state: state, grant (PORT_NBITS), rr_ptr (PORT_NBITS), burst_cnt (4 bits), output register, desc_cnt.
- FSM states: IDLE, SETTLE, POP, HOLD.
- IDLE
  - If enable=1 and ~fifo_empty is nonzero, grant <= the first non-empty port at or after rr_ptr, searching cyclically upward. Next state is SETTLE.
  - Otherwise stay in IDLE.
- SETTLE: one cycle that covers the registered FIFO read path and the grant-mux registration. Next state is POP.
- POP
  - fifo_rd[grant]=1 for this cycle only.
  - out_desc <= fifo_dout[grant]; out_src <= grant; out_valid <= 1; burst_cnt <= burst_cnt+1.
  - Next state is HOLD.
- HOLD
  - out_valid, out_desc and out_src are held stable while out_ready=0.
  - On out_ready=1: out_valid <= 0 and desc_cnt <= desc_cnt+1.
  - If, in that same cycle, enable=1, burst_cnt < MAX_BURST and fifo_empty[grant]=0, the next state is POP with the same grant.
  - Otherwise rr_ptr <= (grant+1) mod NUM_PORTS, burst_cnt <= 0, and the next state is IDLE.
- fifo_rd is asserted only for a port observed non-empty. The arbiter never pops an empty FIFO and never has two pops outstanding.
- When enable=0 during HOLD, the handshake still completes, the burst then terminates and rr_ptr advances. When enable=0 in SETTLE or POP, the descriptor is still popped and delivered.
- busy = (state != IDLE).
- desc_cnt is a 32-bit counter that wraps from 0xFFFFFFFF to 0.

## Timing
- Reset (rstn=0 at a posedge): state=IDLE; grant, rr_ptr, burst_cnt = 0; out_valid=0, out_desc=0, out_src=0, fifo_rd=0, busy=0, desc_cnt=0.
- Reset mid-operation: a descriptor already popped and held in HOLD is discarded. out_valid is 0 in the cycle after the reset edge.
- First-descriptor latency:
  - IDLE sees a non-empty port in cycle t.
  - SETTLE in t+1.
  - fifo_rd pulse in t+2.
  - out_valid=1 in t+3.
- Burst throughput with out_ready=1: one descriptor every 2 cycles (HOLD, POP, HOLD, ...).
- Port switch costs 4 cycles per descriptor: HOLD, IDLE, SETTLE, POP.
- Head validity in the burst path
  - The FIFO updates the head one cycle after a pop.
  - HOLD always separates two POPs, so fifo_dout is valid in each POP.
  - A write landing in cycle h-1 clears fifo_empty in cycle h (HOLD), and the data is on fifo_dout in POP (cycle h+1).
- Wrap-around: rr_ptr = NUM_PORTS-1 advances to 0. With only the current port non-empty after its burst ends, that port is regranted via IDLE.
- out_ready high while out_valid=0 has no effect.

## Test plan
- Reset: hold rstn=0 for 3 cycles with all FIFOs non-empty -> all outputs 0, fifo_rd never asserted. Release -> first fifo_rd[0] 2 cycles after IDLE.
- Single port: only port 2 holds descriptor 0xA5 (zero-extended), out_ready=1 -> fifo_rd=4'b0100 in one cycle, out_valid one cycle later with out_desc=0xA5 and out_src=2, then IDLE. desc_cnt=1.
- Fairness: 4 ports with 6 descriptors each, MAX_BURST=4, out_ready=1 -> out_src sequence 0×4, 1×4, 2×4, 3×4, 0×2, 1×2, 2×2, 3×2. desc_cnt=24, no descriptor duplicated or lost, per-port order preserved.
- Backpressure: out_ready=0 for 10 cycles while HOLD -> out_valid, out_desc and out_src stable, fifo_rd=0 throughout. Descriptor accepted on the first out_ready=1.
- Enable drop: enable falls during HOLD of the 2nd descriptor of a port-1 burst -> that descriptor completes, then IDLE with rr_ptr=2 and no further fifo_rd until enable=1.
- Reset mid-HOLD: rstn=0 while out_valid=1 -> out_valid=0 and desc_cnt=0 the next cycle. After release, arbitration restarts from port 0.
